// File: rtl/universal_ff_bank.sv
// Bank of WIDTH independent D/T/SR/JK flip-flops that update on a divided-down tick.
// A free-running divider produces the tick strobe and an observation-only slow_clk square wave.
module universal_ff_bank #(
  parameter int WIDTH   = 8,
  parameter int DIVISOR = 100000000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [2*WIDTH-1:0] mode,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               err_clr,
  output logic [WIDTH-1:0]   q,
  output logic [WIDTH-1:0]   q_bar,
  output logic               tick,
  output logic               slow_clk,
  output logic [WIDTH-1:0]   sr_err
);

  localparam int CNT_W = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DIVISOR - 1);
  localparam logic [CNT_W-1:0] HALF = CNT_W'(DIVISOR / 2);

  typedef enum logic [1:0] {
    MODE_D  = 2'b00,
    MODE_T  = 2'b01,
    MODE_SR = 2'b10,
    MODE_JK = 2'b11
  } ff_mode_e;

  logic [CNT_W-1:0] counter_q, counter_d;
  logic             slow_clk_q, slow_clk_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] q_bar_q, q_bar_d;
  logic [WIDTH-1:0] sr_err_q, sr_err_d;
  logic [WIDTH-1:0] sr_set;

  // SR 11 holds the current value so the output is always defined
  function automatic logic ff_next(input logic [1:0] m, input logic cur,
                                   input logic in_a, input logic in_b);
    logic nxt;
    nxt = cur;
    case (ff_mode_e'(m))
      MODE_D:  nxt = in_a;
      MODE_T:  nxt = in_a ? ~cur : cur;
      MODE_SR: begin
        case ({in_a, in_b})
          2'b10:   nxt = 1'b1;
          2'b01:   nxt = 1'b0;
          default: nxt = cur;
        endcase
      end
      MODE_JK: begin
        case ({in_a, in_b})
          2'b10:   nxt = 1'b1;
          2'b01:   nxt = 1'b0;
          2'b11:   nxt = ~cur;
          default: nxt = cur;
        endcase
      end
      default: nxt = cur;
    endcase
    return nxt;
  endfunction

  // Divider, tick strobe and per-channel next state
  always_comb begin
    tick       = 1'b0;
    counter_d  = counter_q;
    slow_clk_d = (counter_q < HALF);
    q_d        = q_q;
    sr_set     = '0;
    if (reset) begin
      tick = 1'b0;
    end else begin
      tick = (counter_q == LAST);
    end
    if (counter_q == LAST) begin
      counter_d = '0;
    end else begin
      counter_d = counter_q + CNT_W'(1);
    end
    for (int i = 0; i < WIDTH; i++) begin
      if (tick) begin
        q_d[i]    = ff_next(mode[2*i +: 2], q_q[i], a[i], b[i]);
        sr_set[i] = (mode[2*i +: 2] == MODE_SR) && a[i] && b[i];
      end else begin
        q_d[i]    = q_q[i];
        sr_set[i] = 1'b0;
      end
    end
    // A coincident set beats the clear for that channel only
    if (err_clr) begin
      sr_err_d = sr_set;
    end else begin
      sr_err_d = sr_err_q | sr_set;
    end
    q_bar_d = ~q_d;
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      counter_q  <= '0;
      slow_clk_q <= 1'b0;
      q_q        <= '0;
      q_bar_q    <= '1;
      sr_err_q   <= '0;
    end else begin
      counter_q  <= counter_d;
      slow_clk_q <= slow_clk_d;
      q_q        <= q_d;
      q_bar_q    <= q_bar_d;
      sr_err_q   <= sr_err_d;
    end
  end

  assign q        = q_q;
  assign q_bar    = q_bar_q;
  assign slow_clk = slow_clk_q;
  assign sr_err   = sr_err_q;

endmodule

// File: doc/universal_ff_bank.md
UNIVERSAL_FF_BANK -- requirements
Module: universal_ff_bank

Interface
REQ-001 Parameter: WIDTH, default 8, number of independent flip-flop channels (1..32).
REQ-002 Parameter: DIVISOR, default 100000000, clk cycles per update tick (>= 1). The counter width SHALL be ceil(log2(DIVISOR)), minimum 1.
REQ-003 Port: clk  input  1  single clock; all state changes on its rising edge.
REQ-004 Port: reset  input  1  synchronous, active-high reset.
REQ-005 Port: mode  input  2*WIDTH  per-channel mode, bits [2i+1:2i] for channel i: 00 = D, 01 = T, 10 = SR, 11 = JK.
REQ-006 Port: a  input  WIDTH  per-channel primary input: D, T, S or J, depending on mode.
REQ-007 Port: b  input  WIDTH  per-channel secondary input: R or K; ignored in D and T modes.
REQ-008 Port: err_clr  input  1  clears all sticky SR error flags.
REQ-009 Port: q  output  WIDTH  registered channel state.
REQ-010 Port: q_bar  output  WIDTH  registered complement of q.
REQ-011 Port: tick  output  1  one-clk-wide update strobe.
REQ-012 Port: slow_clk  output  1  registered ~50% duty square wave with period DIVISOR clk cycles; for observation only, never used as a clock.
REQ-013 Port: sr_err  output  WIDTH  sticky flag per channel: S=R=1 was sampled in SR mode.

Function
REQ-014 The divider counter SHALL count 0..DIVISOR-1 and wrap to 0; it advances every clk cycle when not in reset.
REQ-015 tick SHALL be combinationally high exactly in the cycle where counter == DIVISOR-1.
REQ-016 When DIVISOR = 1, tick SHALL be high in every non-reset cycle.
REQ-017 slow_clk SHALL be registered each clk edge as (counter < DIVISOR/2), with integer division; when DIVISOR = 1 it therefore stays 0.
REQ-018 Channels SHALL update only on the clk edge that ends a tick cycle; at all other edges, q, q_bar and sr_err set-events SHALL hold.
REQ-019 mode, a and b SHALL be sampled at that tick edge only; changes between ticks SHALL have no effect.
REQ-020 D mode: q <= a.
REQ-021 T mode: a = 1 toggles q; a = 0 holds.
REQ-022 SR mode behaviour:
 - 00 holds.
 - 01 gives q = 0.
 - 10 gives q = 1.
 - 11 holds q and sets sr_err[i] = 1; the output SHALL never be X.
REQ-023 JK mode behaviour: 00 holds; 01 gives q = 0; 10 gives q = 1; 11 toggles.
REQ-024 q_bar SHALL equal ~q bit-for-bit in every cycle, including reset.
REQ-025 sr_err[i] SHALL remain 1 until err_clr or reset.
REQ-026 err_clr SHALL clear sr_err on any edge, whether or not tick is high.
REQ-027 If err_clr is high and a new SR 11 event occurs at the same edge, set SHALL win for that channel; other channels SHALL clear.
REQ-028 Channels SHALL be fully independent; mixed modes across channels in the same tick are legal.

Reset
REQ-029 While reset = 1 at a clk edge, the block SHALL set counter = 0, q = 0, q_bar = all 1s, sr_err = 0 and slow_clk = 0.
REQ-030 tick SHALL be 0 while reset is high, regardless of counter value.
REQ-031 Reset asserted mid-period SHALL discard the partial count. After release, the first tick SHALL occur in the DIVISOR-th cycle.
REQ-032 Reset SHALL override err_clr and any pending tick update in the same cycle.

Verification (WIDTH = 4, DIVISOR = 4 unless stated)
REQ-033 Release reset, then hold all inputs at 0 -> tick high in cycles 4, 8, 12 after release; slow_clk pattern 1,1,0,0 repeating, one cycle behind the counter; q = 0000, q_bar = 1111 throughout.
REQ-034 Set mode = all JK, a = b = 1111 -> q alternates 1111, 0000, 1111 on successive ticks and is unchanged between ticks.
REQ-035 Channel-dependent stimulus:
 - Setup: ch0 D (a=1), ch1 T (a=1), ch2 SR (S=1, R=0), ch3 JK (J=0, K=1); q starts at 0000.
 - First tick: q = 0111.
 - Second tick: q = 0101, because only ch1 toggles.
REQ-036 ch2 in SR mode with S=R=1 at a tick -> q[2] holds and sr_err = 0100. Raising err_clr with no tick -> sr_err = 0000 on the next edge. err_clr and S=R=1 coincident at a tick -> sr_err[2] = 1.
REQ-037 Assert reset for 1 cycle at counter = 2 while q = 1111 -> q = 0000 and q_bar = 1111 at that edge; next tick 4 cycles after release.
REQ-038 With DIVISOR = 1 and ch0 in T mode with a = 1 -> tick constantly high and q[0] toggling every clk.
